move_sched: RTL

//  Sequences single-cycle direction pulses L/R/U/D from the keyboard debouncer into paced position moves.

---
 rtl/move_sched_if.sv | 28 ++
 rtl/move_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_sched_if.sv
// Move handshake bus between the move scheduler and the game-board datapath.
// The scheduler drives the request side (master); the datapath answers with move_ack (slave).
interface move_sched_if #(
    parameter int XW = 5,
    parameter int YW = 5
);
    logic          move_req;
    logic [1:0]    move_dir;
    logic [XW-1:0] tgt_x;
    logic [YW-1:0] tgt_y;
    logic          move_ack;

    modport master (
        output move_req,
        output move_dir,
        output tgt_x,
        output tgt_y,
        input  move_ack
    );

    modport slave (
        input  move_req,
        input  move_dir,
        input  tgt_x,
        input  tgt_y,
        output move_ack
    );
endinterface

// File: rtl/move_sched.sv
// move_sched: buffers debounced L/R/U/D pulses in a small FIFO and issues them one at a
// time as paced, bounds-checked position moves over a req/ack handshake.
// The block owns the committed player position (pos_x, pos_y).
// Optional feature: define MOVE_WRAP_EN to make out-of-range targets wrap to the
// opposite edge instead of being discarded.
// The interface instance connected to bus must use the same XW/YW as this module.
module move_sched #(
    parameter int DEPTH  = 4,
    parameter int XW     = 5,
    parameter int YW     = 5,
    parameter int X_MAX  = 19,
    parameter int Y_MAX  = 14,
    parameter int X_INIT = 9,
    parameter int Y_INIT = 7,
    parameter int PACE   = 187500
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          L,
    input  logic          R,
    input  logic          U,
    input  logic          D,
    move_sched_if.master  bus,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic          busy,
    output logic          ovf
);
    localparam int AW = $clog2(DEPTH);
    // Counter is wide enough for PACE-1 and never degenerates to a zero-width replication.
    localparam int CW = $clog2(PACE + 1) + 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LOAD = CW'(PACE - 1);
    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [XW:0]   X_ONE    = {{XW{1'b0}}, 1'b1};
    localparam logic [YW:0]   Y_ONE    = {{YW{1'b0}}, 1'b1};
    localparam logic [XW:0]   X_LIM    = (XW+1)'(X_MAX);
    localparam logic [YW:0]   Y_LIM    = (YW+1)'(Y_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t        state_r, state_nxt;
    logic [1:0]    fifo_mem [DEPTH];
    logic [AW:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0] cnt_r;
    logic          req_r, busy_r, ovf_r;
    logic [1:0]    dir_r;
    logic [XW-1:0] tgt_x_r, pos_x_r, tgt_x_s;
    logic [YW-1:0] tgt_y_r, pos_y_r, tgt_y_s;
    logic [XW:0]   nx_s;
    logic [YW:0]   ny_s;
    logic [1:0]    win_dir_s, head_s;
    logic          any_s, multi_s, empty_s, full_s, wr_s, pop_s, issue_s, commit_s;
    logic          in_bounds_s, ovf_nxt, busy_nxt;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head_s  = fifo_mem[rd_ptr_r[AW-1:0]];

    // Input arbitration: L beats R beats U beats D; losers and full-FIFO drops raise ovf.
    always_comb begin
        any_s   = L | R | U | D;
        multi_s = ($countones({L, R, U, D}) > 32'd1);
        if (L) begin
            win_dir_s = 2'b00;
        end else if (R) begin
            win_dir_s = 2'b01;
        end else if (U) begin
            win_dir_s = 2'b10;
        end else begin
            win_dir_s = 2'b11;
        end
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
        wr_s       = any_s && (!full_s || pop_s);
        ovf_nxt    = multi_s || (any_s && full_s && !pop_s);
        wr_ptr_nxt = wr_s  ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_nxt = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        busy_nxt   = (state_nxt != IDLE) || (wr_ptr_nxt != rd_ptr_nxt);
    end

    // Candidate target for the FIFO head, one extra bit so stepping below zero is visible.
    always_comb begin
        nx_s = {1'b0, pos_x_r};
        ny_s = {1'b0, pos_y_r};
        case (head_s)
            2'b00:   nx_s = {1'b0, pos_x_r} - X_ONE;
            2'b01:   nx_s = {1'b0, pos_x_r} + X_ONE;
            2'b10:   ny_s = {1'b0, pos_y_r} - Y_ONE;
            2'b11:   ny_s = {1'b0, pos_y_r} + Y_ONE;
            default: nx_s = {1'b0, pos_x_r};
        endcase
    end

    // Board bounds: wrap to the opposite edge or flag the move for discard.
    always_comb begin
`ifdef MOVE_WRAP_EN
        in_bounds_s = 1'b1;
        if (nx_s > X_LIM) begin
            tgt_x_s = (head_s == 2'b00) ? XW'(X_MAX) : {XW{1'b0}};
        end else begin
            tgt_x_s = nx_s[XW-1:0];
        end
        if (ny_s > Y_LIM) begin
            tgt_y_s = (head_s == 2'b10) ? YW'(Y_MAX) : {YW{1'b0}};
        end else begin
            tgt_y_s = ny_s[YW-1:0];
        end
`else
        in_bounds_s = (nx_s <= X_LIM) && (ny_s <= Y_LIM);
        tgt_x_s     = nx_s[XW-1:0];
        tgt_y_s     = ny_s[YW-1:0];
`endif
    end

    // Scheduler next state: pop in IDLE, wait for ack in ISSUE, count down in COOL.
    always_comb begin
        state_nxt = state_r;
        pop_s     = 1'b0;
        issue_s   = 1'b0;
        commit_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s = 1'b1;
                    if (in_bounds_s) begin
                        issue_s   = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (bus.move_ack) begin
                    commit_s  = 1'b1;
                    state_nxt = COOL;
                end else begin
                    state_nxt = ISSUE;
                end
            end
            COOL: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = COOL;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Scheduler state register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Command FIFO storage and pointers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= 2'b00;
            end
        end else begin
            if (wr_s) begin
                fifo_mem[wr_ptr_r[AW-1:0]] <= win_dir_s;
            end
            wr_ptr_r <= wr_ptr_nxt;
            rd_ptr_r <= rd_ptr_nxt;
        end
    end

    // Handshake registers, committed position and cool-down counter.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            req_r   <= 1'b0;
            dir_r   <= 2'b00;
            tgt_x_r <= {XW{1'b0}};
            tgt_y_r <= {YW{1'b0}};
            pos_x_r <= XW'(X_INIT);
            pos_y_r <= YW'(Y_INIT);
            cnt_r   <= CNT_ZERO;
        end else begin
            if (issue_s) begin
                req_r   <= 1'b1;
                dir_r   <= head_s;
                tgt_x_r <= tgt_x_s;
                tgt_y_r <= tgt_y_s;
            end else if (commit_s) begin
                req_r   <= 1'b0;
                pos_x_r <= tgt_x_r;
                pos_y_r <= tgt_y_r;
                cnt_r   <= CNT_LOAD;
            end else if ((state_r == COOL) && (cnt_r != CNT_ZERO)) begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end
    end

    // Registered status flags.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            busy_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            busy_r <= busy_nxt;
            ovf_r  <= ovf_nxt;
        end
    end

    assign bus.move_req = req_r;
    assign bus.move_dir = dir_r;
    assign bus.tgt_x    = tgt_x_r;
    assign bus.tgt_y    = tgt_y_r;
    assign pos_x        = pos_x_r;
    assign pos_y        = pos_y_r;
    assign busy         = busy_r;
    assign ovf          = ovf_r;
endmodule
